// File: rtl/crc_frame_arbiter_pkg.sv
// Shared types, constants and X25 helpers for the CRC frame arbiter.
package crc_frame_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      INIT  = 2'd1,
      RUN   = 2'd2,
      CHECK = 2'd3
   } state_t;

   localparam logic [15:0] CRC_INIT      = 16'hFFFF;
   localparam int          MIN_FRAME_LEN = 3;

   function automatic logic [15:0] reflect16(input logic [15:0] v);
      logic [15:0] r;
      for (int i = 0; i < 16; i++) begin
         r[i] = v[15-i];
      end
      return r;
   endfunction

   // Reflect, invert, then swap bytes to obtain the standard X25 FCS.
   function automatic logic [15:0] x25Finish(input logic [15:0] crc);
      logic [15:0] f;
      f = ~reflect16(crc);
      return {f[7:0], f[15:8]};
   endfunction

endpackage

// File: rtl/crc_frame_arbiter_crc16d8.sv
// CRC16D8 engine: one byte per enabled cycle, poly 0x1021, LSB-first input.
module CRC16D8
   import crc_frame_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [7:0]  d,
   output logic [15:0] crcOut
);

   logic [15:0] crc_q;
   logic [15:0] crc_d;

   always_comb begin
      crc_d = crc_q ^ {8'h00, d};
      for (int i = 0; i < 8; i++) begin
         crc_d = crc_d[0] ? ((crc_d >> 1) ^ 16'h8408) : (crc_d >> 1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         crc_q <= CRC_INIT;
      end else if (en) begin
         crc_q <= crc_d;
      end
   end

   // Each register byte is presented MSB-first, matching the wire bit order.
   always_comb begin
      crcOut = '0;
      for (int i = 0; i < 8; i++) begin
         crcOut[8+i] = crc_q[15-i];
         crcOut[i]   = crc_q[7-i];
      end
   end

endmodule

// File: rtl/crc_frame_arbiter.sv
// Round-robin frame arbiter sharing one CRC16D8 engine between channels A and B.
module crc_frame_arbiter
   import crc_frame_pkg::*;
#(
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rstN,
   input  logic [7:0]           aData,
   input  logic                 aValid,
   input  logic                 aLast,
   output logic                 aReady,
   input  logic [7:0]           bData,
   input  logic                 bValid,
   input  logic                 bLast,
   output logic                 bReady,
   output logic                 resValid,
   output logic                 resChan,
   output logic                 resPass,
   output logic                 resRunt,
   output logic [15:0]          resCrc,
   input  logic                 errClr,
   output logic [ERR_CNT_W-1:0] errCntA,
   output logic [ERR_CNT_W-1:0] errCntB
);

   state_t               state_q, state_d;
   logic                 grant_q, grant_d;
   logic                 engClr_q;
   logic [1:0]           count_q;
   logic [7:0]           dly0_q, dly1_q;
   logic                 resValid_q, resChan_q, resPass_q, resRunt_q;
   logic [15:0]          resCrc_q;
   logic [ERR_CNT_W-1:0] errCntA_q, errCntB_q;

   logic        selValid, selLast, accept, engEn, engRst, runt, pass;
   logic [7:0]  selData;
   logic [15:0] crcOut, fcsCalc;

   assign selValid = grant_q ? bValid : aValid;
   assign selLast  = grant_q ? bLast  : aLast;
   assign selData  = grant_q ? bData  : aData;
   assign accept   = (state_q == RUN) && selValid;
   assign engEn    = accept && (count_q >= 2'd2);
   assign engRst   = ~rstN | engClr_q;
   assign fcsCalc  = x25Finish(crcOut);
   assign runt     = int'(count_q) < MIN_FRAME_LEN;
   assign pass     = !runt && ({dly1_q, dly0_q} == {fcsCalc[7:0], fcsCalc[15:8]});

   // The delay line keeps the two newest bytes, so the FCS never reaches the engine.
   CRC16D8 uEngine (
      .clk    (clk),
      .rst    (engRst),
      .en     (engEn),
      .d      (dly1_q),
      .crcOut (crcOut)
   );

   // grant_q doubles as the last-granted channel for round-robin ties.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      unique case (state_q)
         IDLE: begin
            if (aValid || bValid) begin
               state_d = INIT;
               grant_d = (aValid && bValid) ? ~grant_q : bValid;
            end
         end
         INIT:    state_d = RUN;
         RUN:     if (accept && selLast) state_d = CHECK;
         CHECK:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q    <= IDLE;
         grant_q    <= 1'b1;
         engClr_q   <= 1'b0;
         count_q    <= '0;
         dly0_q     <= '0;
         dly1_q     <= '0;
         resValid_q <= 1'b0;
         resChan_q  <= 1'b0;
         resPass_q  <= 1'b0;
         resRunt_q  <= 1'b0;
         resCrc_q   <= '0;
         errCntA_q  <= '0;
         errCntB_q  <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         engClr_q   <= (state_d == INIT);
         resValid_q <= (state_q == CHECK);
         if (state_q == INIT) begin
            count_q <= '0;
            dly0_q  <= '0;
            dly1_q  <= '0;
         end else if (accept) begin
            dly0_q <= selData;
            dly1_q <= dly0_q;
            if (count_q != 2'd3) count_q <= count_q + 2'd1;
         end
         if (state_q == CHECK) begin
            resChan_q <= grant_q;
            resPass_q <= pass;
            resRunt_q <= runt;
            resCrc_q  <= fcsCalc;
         end
         if (errClr) begin
            errCntA_q <= '0;
            errCntB_q <= '0;
         end else if (state_q == CHECK && !pass) begin
            if (!grant_q && !(&errCntA_q)) errCntA_q <= errCntA_q + ERR_CNT_W'(1);
            if (grant_q && !(&errCntB_q))  errCntB_q <= errCntB_q + ERR_CNT_W'(1);
         end
      end
   end

   assign aReady   = (state_q == RUN) && !grant_q;
   assign bReady   = (state_q == RUN) && grant_q;
   assign resValid = resValid_q;
   assign resChan  = resChan_q;
   assign resPass  = resPass_q;
   assign resRunt  = resRunt_q;
   assign resCrc   = resCrc_q;
   assign errCntA  = errCntA_q;
   assign errCntB  = errCntB_q;

endmodule
